// File: rtl/mac_pkg.sv
// mac_pkg: shared widths and FSM state encoding for the mac_feeder slice.
// Rev 1.0
`default_nettype none

package mac_pkg;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_LEN_W        = 16;
  localparam int DEF_DRAIN_CYCLES = 2;
  localparam int ACC_W            = 2 * DEF_DATA_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mac_mul_stage.sv
// mac_mul_stage: registered full-width multiplier, 1-cycle latency, flushable.
// Rev 1.0 -- MAC_FEEDER_SIGNED_EN selects two's-complement operands.
`default_nettype none

module mac_mul_stage
  import mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   product
);

  localparam int AW = 2 * DATA_W;

  logic          valid_d, valid_q;
  logic [AW-1:0] product_d, product_q;
  logic [AW-1:0] full_w;

`ifdef MAC_FEEDER_SIGNED_EN
  logic signed [AW-1:0] a_ext_w, b_ext_w;
  assign a_ext_w = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_ext_w = {{DATA_W{b[DATA_W-1]}}, b};
  assign full_w  = a_ext_w * b_ext_w;
`else
  assign full_w  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

  always_comb begin
    valid_d   = in_valid;
    product_d = product_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid) begin
      product_d = full_w;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      product_q <= '0;
    end else begin
      valid_q   <= valid_d;
      product_q <= product_d;
    end
  end

  assign out_valid = valid_q;
  assign product   = product_q;

endmodule

`default_nettype wire

// File: rtl/mac_feeder.sv
// mac_feeder: streams operand products into an external accumulator and returns the dot product.
// Rev 1.0 -- MAC_FEEDER_SIGNED_EN (in mac_mul_stage) selects signed operands.
`default_nettype none

module mac_feeder
  import mac_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int LEN_W        = DEF_LEN_W,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     vec_len,
  input  logic                 abort,
  input  logic                 op_valid,
  input  logic [DATA_W-1:0]    op_a,
  input  logic [DATA_W-1:0]    op_b,
  output logic                 op_ready,
  output logic                 acc_clear,
  output logic                 acc_accumulate,
  output logic [2*DATA_W-1:0]  acc_data,
  input  logic [2*DATA_W-1:0]  acc_result,
  output logic [2*DATA_W-1:0]  result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 busy
);

  localparam int AW  = 2 * DATA_W;
  localparam int DCW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_e         state_d, state_q;
  logic [LEN_W-1:0] remaining_d, remaining_q;
  logic [DCW-1:0] drain_cnt_d, drain_cnt_q;
  logic [AW-1:0]  result_d, result_q;
  logic           op_ready_d, op_ready_q;
  logic           acc_clear_d, acc_clear_q;
  logic           result_valid_d, result_valid_q;
  logic           busy_d, busy_q;

  logic           abort_take_w;
  logic           handshake_w;
  logic           mul_valid_w;
  logic [AW-1:0]  mul_product_w;

  assign abort_take_w = abort && (state_q != IDLE);
  assign handshake_w  = op_valid && op_ready_q;

  mac_mul_stage #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (abort_take_w),
    .in_valid  (handshake_w),
    .a         (op_a),
    .b         (op_b),
    .out_valid (mul_valid_w),
    .product   (mul_product_w)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    drain_cnt_d = drain_cnt_q;
    result_d    = result_q;
    acc_clear_d = 1'b0;

    if (abort_take_w) begin
      state_d     = IDLE;
      acc_clear_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            remaining_d = vec_len;
            state_d     = CLEAR;
            acc_clear_d = 1'b1;
          end
        end
        CLEAR: begin
          drain_cnt_d = '0;
          state_d     = (remaining_q != '0) ? STREAM : DRAIN;
        end
        STREAM: begin
          drain_cnt_d = '0;
          if (handshake_w) begin
            remaining_d = remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          // Count only once the last product has left the multiplier stage.
          if (mul_valid_w) begin
            drain_cnt_d = '0;
          end else if (drain_cnt_q == DCW'(DRAIN_CYCLES)) begin
            result_d = acc_result;
            state_d  = DONE;
          end else begin
            drain_cnt_d = drain_cnt_q + DCW'(1);
          end
        end
        DONE: begin
          if (result_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    op_ready_d     = (state_d == STREAM);
    result_valid_d = (state_d == DONE);
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      remaining_q    <= '0;
      drain_cnt_q    <= '0;
      result_q       <= '0;
      op_ready_q     <= 1'b0;
      acc_clear_q    <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      drain_cnt_q    <= drain_cnt_d;
      result_q       <= result_d;
      op_ready_q     <= op_ready_d;
      acc_clear_q    <= acc_clear_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign op_ready       = op_ready_q;
  assign acc_clear      = acc_clear_q;
  assign acc_accumulate = mul_valid_w;
  assign acc_data       = mul_product_w;
  assign result         = result_q;
  assign result_valid   = result_valid_q;
  assign busy           = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: scoreboard bench for mac_feeder driving a behavioural 64-bit accumulator.
// Rev 1.0 -- honours MAC_FEEDER_SIGNED_EN in its reference model.
`default_nettype none

module tb_mac_feeder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] vec_len = '0;
  logic        abort = 1'b0;
  logic        op_valid = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        result_ready = 1'b1;
  logic        op_ready, acc_clear, acc_accumulate, result_valid, busy;
  logic [63:0] acc_data, result;
  logic [63:0] acc_q = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_clr = 0;
  int n_acc = 0;
  int c0_clr, c0_acc;
  int last_hs_cyc = 0;
  int rv_cyc = 0;
  bit rv_seen = 1'b0;

  logic [63:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] va[8];
  logic [31:0] vb[8];

  mac_feeder u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .vec_len        (vec_len),
    .abort          (abort),
    .op_valid       (op_valid),
    .op_a           (op_a),
    .op_b           (op_b),
    .op_ready       (op_ready),
    .acc_clear      (acc_clear),
    .acc_accumulate (acc_accumulate),
    .acc_data       (acc_data),
    .acc_result     (acc_q),
    .result         (result),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (acc_clear) acc_q <= '0;
    else if (acc_accumulate) acc_q <= acc_q + acc_data;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
`ifdef MAC_FEEDER_SIGNED_EN
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
`else
    return {32'b0, a} * {32'b0, b};
`endif
  endfunction

  // Sideband counters and the scoreboard pop all sample on the falling edge.
  always @(negedge clk) begin
    if (acc_clear) n_clr++;
    if (acc_accumulate) n_acc++;
    if (result_valid && !rv_seen) begin
      rv_seen = 1'b1;
      rv_cyc  = cyc;
    end
    if (result_valid && result_ready) begin
      if (exp_q.size() == 0) check_eq("sb_nonempty", 64'(exp_q.size()), 64'd1);
      else check_eq(tag_q.pop_front(), result, exp_q.pop_front());
    end
  end

  task automatic run_op(input int len, input int gap, input int abort_after, input string tag);
    int i, gap_left, budget;
    logic [63:0] sum;
    @(posedge clk); #1;
    c0_clr  = n_clr;
    c0_acc  = n_acc;
    rv_seen = 1'b0;
    sum = '0;
    for (int k = 0; k < len; k++) sum = sum + ref_prod(va[k], vb[k]);
    if (abort_after == 0) begin
      exp_q.push_back(sum);
      tag_q.push_back({tag, "_result"});
    end
    @(negedge clk);
    start = 1'b1;
    vec_len = len[15:0];
    @(negedge clk);
    start = 1'b0;
    i = 0; gap_left = 0; budget = 0;
    while (i < len && budget < 200 && !(abort_after != 0 && i == abort_after)) begin
      if (gap_left > 0) begin
        op_valid = 1'b0;
        gap_left--;
      end else begin
        op_valid = 1'b1;
        op_a = va[i];
        op_b = vb[i];
        if (op_ready) begin
          i++;
          gap_left = gap;
          last_hs_cyc = cyc + 1;
        end
      end
      budget++;
      @(negedge clk);
    end
    op_valid = 1'b0;
    check_eq({tag, "_hs"}, 64'(i), 64'((abort_after != 0) ? abort_after : len));
    if (abort_after != 0) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_eq({tag, "_abort_busy"}, 64'(busy), 64'd0);
      check_eq({tag, "_abort_clr"}, 64'(acc_clear), 64'd1);
      check_eq({tag, "_abort_acc"}, 64'(acc_accumulate), 64'd0);
      repeat (10) @(negedge clk);
      @(posedge clk); #1;
      check_eq({tag, "_clr_cnt"}, 64'(n_clr - c0_clr), 64'd2);
      check_eq({tag, "_acc_cnt"}, 64'(n_acc - c0_acc), 64'(abort_after));
      check_eq({tag, "_no_rv"}, 64'(rv_seen), 64'd0);
    end else begin
      budget = 0;
      while (!rv_seen && budget < 100) begin
        @(negedge clk);
        budget++;
      end
      check_eq({tag, "_rv_seen"}, 64'(rv_seen), 64'd1);
      if (result_ready) begin
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
          @(negedge clk);
          budget++;
        end
        check_eq({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        check_eq({tag, "_clr_cnt"}, 64'(n_clr - c0_clr), 64'd1);
        check_eq({tag, "_acc_cnt"}, 64'(n_acc - c0_acc), 64'(len));
        if (len > 0) check_eq({tag, "_latency"}, 64'(rv_cyc - last_hs_cyc), 64'd4);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit stable;
    int budget;
    #12;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ready_clr_acc", {61'd0, op_ready, acc_clear, acc_accumulate}, 64'd0);
    check_eq("rst_rv", 64'(result_valid), 64'd0);
    check_eq("rst_result", result, 64'd0);
    check_eq("rst_acc_data", acc_data, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    va[0] = 32'd1; vb[0] = 32'd2;
    va[1] = 32'd3; vb[1] = 32'd4;
    va[2] = 32'd5; vb[2] = 32'd6;
    run_op(3, 0, 0, "dot3");
    run_op(3, 2, 0, "dot3_gap");

    va[0] = 32'hFFFF_FFFF; vb[0] = 32'd5;
    run_op(1, 0, 0, "max_x5");

    va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF;
    run_op(2, 0, 0, "wrap");

    result_ready = 1'b0;
    run_op(0, 0, 0, "len0");
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!result_valid || result !== 64'd0) stable = 1'b0;
      start = (k == 4);
      vec_len = 16'd5;
    end
    start = 1'b0;
    check_eq("len0_hold", 64'(stable), 64'd1);
    @(posedge clk); #1;
    result_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check_eq("len0_drained", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("len0_idle", 64'(busy), 64'd0);
    check_eq("len0_clr_cnt", 64'(n_clr - c0_clr), 64'd1);
    check_eq("len0_acc_cnt", 64'(n_acc - c0_acc), 64'd0);

    va[0] = 32'd1; vb[0] = 32'd1;
    va[1] = 32'd2; vb[1] = 32'd2;
    va[2] = 32'd3; vb[2] = 32'd3;
    va[3] = 32'd4; vb[3] = 32'd4;
    run_op(4, 0, 2, "abort");

    va[0] = 32'd7; vb[0] = 32'd6;
    run_op(1, 0, 0, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
